// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
//
// Hazard unit for the RV32I pipeline. It detects load-use hazards for the
// instruction sitting in IF/ID. Two sources of hazard are checked:
//   * the direct case: the instruction now in ID/EX is a load whose rd
//     matches a source register of the IF/ID instruction;
//   * the scoreboard case: an earlier load whose data is still in flight
//     (extra memory latency) has its per-register counter nonzero.
// Per-register counters are armed when a load leaves ID/EX. They count
// down only while data memory is ready, so a stalled memory keeps the
// hazard alive. Branch/jump flushes take priority over any stall. A
// saturating counter records how many cycles the pipeline was stalled.
//
// Handshake note: there is no valid/ready pair here. Every output is a
// per-cycle level. Stall and the two flush controls are pure functions
// of this cycle's inputs and the registered Busy_vec. Busy_vec and
// Stall_cycles change only at rising clk edges or on async reset.

module pipe_hazard_scoreboard #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int LOAD_LATENCY       = 0,
  parameter int STALL_CNT_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [6:0]                          IF_Opcode,
  input  logic [REGFILE_ADDR_WIDTH-1:0]       IF_Rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0]       IF_Rs2_addr,
  input  logic                                ID_Mem_rd_en,
  input  logic [REGFILE_ADDR_WIDTH-1:0]       ID_Rd_addr,
  input  logic                                ID_Jump,
  input  logic                                EX_PC_Branch,
  input  logic                                Mem_ready,
  output logic                                Stall,
  output logic                                IF_ID_Flush,
  output logic                                EX_Flush,
  output logic [(2**REGFILE_ADDR_WIDTH)-1:0]  Busy_vec,
  output logic [STALL_CNT_WIDTH-1:0]          Stall_cycles
);

  localparam int NUM_REGS = 2 ** REGFILE_ADDR_WIDTH;

  // RV32I major opcodes that matter for source-register use.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ---------------------------------------------------------------------
  // Source-use decode
  // ---------------------------------------------------------------------
  logic use_rs1;
  logic use_rs2;

  // Decode which source registers the IF/ID instruction actually reads.
  // Unknown opcodes read nothing, so they can never cause a stall.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (IF_Opcode)
      OPC_OP, OPC_BRANCH, OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        use_rs1 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  logic rs1_live;
  logic rs2_live;
  logic id_load_live;
  logic direct_hazard;
  logic sb_hazard;

  // x0 is hard-wired to zero, so a match on it is never a real dependency.
  assign rs1_live     = use_rs1 && (IF_Rs1_addr != '0);
  assign rs2_live     = use_rs2 && (IF_Rs2_addr != '0);
  assign id_load_live = ID_Mem_rd_en && (ID_Rd_addr != '0);

  // Classic one-cycle load-use check against the load currently in ID/EX.
  always_comb begin
    direct_hazard = 1'b0;
    if (id_load_live) begin
      if (rs1_live && (ID_Rd_addr == IF_Rs1_addr)) direct_hazard = 1'b1;
      if (rs2_live && (ID_Rd_addr == IF_Rs2_addr)) direct_hazard = 1'b1;
    end
  end

  // Dependency on a load that left ID/EX earlier but whose data is late.
  always_comb begin
    sb_hazard = 1'b0;
    if (rs1_live && Busy_vec[IF_Rs1_addr]) sb_hazard = 1'b1;
    if (rs2_live && Busy_vec[IF_Rs2_addr]) sb_hazard = 1'b1;
  end

  // Flushes discard the IF/ID instruction, so stalling it would be wasted
  // work; any flush therefore masks the stall.
  always_comb begin
    IF_ID_Flush = EX_PC_Branch || ID_Jump;
    EX_Flush    = EX_PC_Branch;
    Stall       = (direct_hazard || sb_hazard) && !IF_ID_Flush;
  end

  // ---------------------------------------------------------------------
  // Per-register scoreboard
  // ---------------------------------------------------------------------
  generate
    if (LOAD_LATENCY > 0) begin : g_sb
      localparam int              CNT_W   = $clog2(LOAD_LATENCY + 1);
      localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(LOAD_LATENCY);

      // A load leaving ID/EX arms its rd entry unless a taken branch is
      // squashing it on the same edge.
      logic issue_en;
      assign issue_en = id_load_live && !EX_PC_Branch;

      // x0 has no storage and is never pending.
      assign Busy_vec[0] = 1'b0;

      for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        logic [CNT_W-1:0] cnt;
        logic             issue_hit;

        assign issue_hit = issue_en &&
                           (ID_Rd_addr == REGFILE_ADDR_WIDTH'(i));

        // Issue reloads (also covers write-after-write); otherwise count
        // down only while memory makes progress.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            cnt <= '0;
          end else if (issue_hit) begin
            cnt <= LAT_VAL;
          end else if (Mem_ready && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
          end
        end

        assign Busy_vec[i] = (cnt != '0);
      end
    end else begin : g_no_sb
      // Without extra latency the direct check alone covers every hazard.
      logic unused_mem_ready;
      assign unused_mem_ready = Mem_ready;
      assign Busy_vec         = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Stall performance counter
  // ---------------------------------------------------------------------

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_cycles <= '0;
    end else if (Stall && (Stall_cycles != '1)) begin
      Stall_cycles <= Stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard
//
// Drives pipe_hazard_scoreboard (LOAD_LATENCY=2, 4-bit stall counter) with
// directed scenarios and then random traffic. A reference model keeps a
// "cycles of memory progress still owed" number per register and predicts
// the outputs each cycle; predictions go into exp_q and a monitor compares
// them against the DUT on the falling edge.

module tb_pipe_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;
  localparam int LL   = 2;
  localparam int SCW  = 4;
  localparam int W    = 3 + NREG + SCW;
  localparam int SAT  = (1 << SCW) - 1;

  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_OP_IMM = 7'b0010011;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JUNK   = 7'b1111111;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      IF_Opcode;
  logic [AW-1:0]   IF_Rs1_addr, IF_Rs2_addr, ID_Rd_addr;
  logic            ID_Mem_rd_en, ID_Jump, EX_PC_Branch, Mem_ready;
  logic            Stall, IF_ID_Flush, EX_Flush;
  logic [NREG-1:0] Busy_vec;
  logic [SCW-1:0]  Stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard #(
    .REGFILE_ADDR_WIDTH (AW),
    .LOAD_LATENCY       (LL),
    .STALL_CNT_WIDTH    (SCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IF_Opcode    (IF_Opcode),
    .IF_Rs1_addr  (IF_Rs1_addr),
    .IF_Rs2_addr  (IF_Rs2_addr),
    .ID_Mem_rd_en (ID_Mem_rd_en),
    .ID_Rd_addr   (ID_Rd_addr),
    .ID_Jump      (ID_Jump),
    .EX_PC_Branch (EX_PC_Branch),
    .Mem_ready    (Mem_ready),
    .Stall        (Stall),
    .IF_ID_Flush  (IF_ID_Flush),
    .EX_Flush     (EX_Flush),
    .Busy_vec     (Busy_vec),
    .Stall_cycles (Stall_cycles)
  );

  // ---------------- reference model ----------------
  // owed[r]: memory-ready cycles still needed before r's load data is usable.
  int owed [NREG];
  int m_stalls;
  logic m_stall;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic int sources_read(input logic [6:0] opc);
    if (opc == O_OP || opc == O_BRANCH || opc == O_STORE) return 2;
    if (opc == O_OP_IMM || opc == O_LOAD || opc == O_JALR) return 1;
    return 0;
  endfunction

  function automatic bit depends(input logic [AW-1:0] src, input logic ld,
                                 input logic [AW-1:0] rd);
    if (src == 0) return 0;
    return (ld && rd == src) || (owed[src] > 0);
  endfunction

  function automatic logic [W-1:0] predict(input logic [6:0] opc,
      input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic ld,
      input logic [AW-1:0] rd, input logic jmp, input logic br);
    logic [NREG-1:0] busy;
    bit hz;
    int n;
    n  = sources_read(opc);
    hz = 0;
    if (n >= 1 && depends(rs1, ld, rd)) hz = 1;
    if (n >= 2 && depends(rs2, ld, rd)) hz = 1;
    m_stall = hz && !br && !jmp;
    for (int r = 0; r < NREG; r++) busy[r] = (owed[r] > 0);
    return {m_stall, br | jmp, br, busy, SCW'(m_stalls)};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NREG; r++) owed[r] = 0;
    m_stalls = 0;
  endfunction

  // State change at a rising edge with reset released.
  function automatic void model_edge(input logic ld, input logic [AW-1:0] rd,
                                     input logic br, input logic mr);
    for (int r = 1; r < NREG; r++) begin
      if (ld && !br && rd == r) owed[r] = LL;
      else if (mr && owed[r] > 0) owed[r] = owed[r] - 1;
    end
    if (m_stall && m_stalls < SAT) m_stalls++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [6:0] opc, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input logic ld,
                      input logic [AW-1:0] rd, input logic jmp,
                      input logic br, input logic mr);
    IF_Opcode    = opc;
    IF_Rs1_addr  = rs1;
    IF_Rs2_addr  = rs2;
    ID_Mem_rd_en = ld;
    ID_Rd_addr   = rd;
    ID_Jump      = jmp;
    EX_PC_Branch = br;
    Mem_ready    = mr;
    exp_q.push_back(predict(opc, rs1, rs2, ld, rd, jmp, br));
    @(posedge clk);
    model_edge(ld, rd, br, mr);
    #1;
  endtask

  // Asynchronous reset: outputs are checked while rst_n is still low.
  task automatic pulse_reset();
    rst_n = 1'b0;
    model_clear();
    exp_q.push_back(predict(IF_Opcode, IF_Rs1_addr, IF_Rs2_addr, ID_Mem_rd_en,
                            ID_Rd_addr, ID_Jump, EX_PC_Branch));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [W-1:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {Stall, IF_ID_Flush, EX_Flush, Busy_vec, Stall_cycles};
        n_vec++;
        if (got_v !== exp_v) begin
          n_miss++;
          $display("FAIL outputs t=%0t got stall=%b ifid=%b exf=%b busy=%h cnt=%0d required stall=%b ifid=%b exf=%b busy=%h cnt=%0d",
                   $time, got_v[W-1], got_v[W-2], got_v[W-3],
                   got_v[NREG+SCW-1:SCW], got_v[SCW-1:0],
                   exp_v[W-1], exp_v[W-2], exp_v[W-3],
                   exp_v[NREG+SCW-1:SCW], exp_v[SCW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] opc_tab [10];

  initial begin : stimulus
    opc_tab = '{O_LOAD, O_OP_IMM, O_AUIPC, O_STORE, O_OP,
                O_LUI, O_BRANCH, O_JALR, O_JAL, O_JUNK};
    IF_Opcode = 7'd0; IF_Rs1_addr = '0; IF_Rs2_addr = '0;
    ID_Mem_rd_en = 1'b0; ID_Rd_addr = '0; ID_Jump = 1'b0;
    EX_PC_Branch = 1'b0; Mem_ready = 1'b1;
    pulse_reset();

    // Load rd=7 then dependent OP_IMM rs1=7 held in IF/ID: 3 stall cycles.
    step(O_OP_IMM, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(O_OP_IMM, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Same, with memory not ready for two cycles after issue.
    step(O_OP_IMM, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(O_OP_IMM, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(O_OP_IMM, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // x0 never hazards; LUI reads no sources.
    step(O_OP, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step(O_OP, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(O_LUI, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
    step(O_LUI, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(O_STORE, 5'd1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(O_NOP_PAD(), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Taken branch squashes the load and masks the stall; jump alone.
    step(O_OP_IMM, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1);
    step(O_OP_IMM, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(O_JAL, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step(O_BRANCH, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);

    // Long direct hazard drives the stall counter into saturation.
    for (int i = 0; i < 20; i++) step(O_OP, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a countdown on x9.
    step(O_JAL, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    step(O_OP, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Random traffic over a small register window to provoke collisions.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step(opc_tab[$urandom_range(0, 9)],
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             $urandom_range(0, 9) < 4,
             ($urandom_range(0, 15) == 0) ? AW'(31) : AW'($urandom_range(0, 7)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  function automatic logic [6:0] O_NOP_PAD();
    return O_OP_IMM;
  endfunction

endmodule
